// File: rtl/ahb_arbiter_2m_if.sv
// Bus-side signal bundle of the two-master AHB-Lite arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface ahb_arbiter_2m_if;
    logic [1:0] HBUSREQ;
    logic [1:0] HLOCK;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic [1:0] HGRANT;
    logic       HMASTER;
    logic       HMASTER_D;
    logic       HMASTLOCK;

    modport slave (
        input  HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
        output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );

    modport master (
        output HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
        input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB-Lite arbiter: tracks the owner's burst so the bus only changes hands at
// legal boundaries, honours locked sequences, and drives address/data-phase master selects.
module ahb_arbiter_2m #(
    parameter logic DEFAULT_MASTER = 1'b0,
    parameter logic PRIORITY_MODE  = 1'b0
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_arbiter_2m_if.slave bus
);

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_FIXED = 2'd1,
        ST_UNDEF = 2'd2
    } arb_state_e;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;

    // Beats remaining after the NONSEQ of a fixed-length burst (len-1).
    function automatic logic [3:0] burst_remaining(input logic [2:0] burst);
        logic [3:0] rem;
        case (burst)
            3'b010, 3'b011: rem = 4'd3;
            3'b100, 3'b101: rem = 4'd7;
            3'b110, 3'b111: rem = 4'd15;
            default:        rem = 4'd0;
        endcase
        return rem;
    endfunction

    arb_state_e state_r;
    arb_state_e state_next_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    logic [1:0] hgrant_r;
    logic       hmaster_r;
    logic       hmaster_d_r;
    logic       hmastlock_r;
    logic       last_r;

    logic       accept_s;
    logic       fixed_s;
    logic       own_req_s;
    logic       own_lock_s;
    logic       rearb_s;
    logic       winner_s;

    assign accept_s   = bus.HREADY & bus.HTRANS[1];
    assign fixed_s    = bus.HBURST[2] | bus.HBURST[1];
    assign own_req_s  = bus.HBUSREQ[hmaster_r];
    assign own_lock_s = bus.HLOCK[hmaster_r];

    assign bus.HGRANT    = hgrant_r;
    assign bus.HMASTER   = hmaster_r;
    assign bus.HMASTER_D = hmaster_d_r;
    assign bus.HMASTLOCK = hmastlock_r;

    // Burst tracker next-state and beat counter; nothing advances while HREADY is low.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (bus.HREADY) begin
            case (bus.HTRANS)
                TR_IDLE: begin
                    state_next_s = ST_OPEN;
                    cnt_next_s   = 4'd0;
                end
                TR_BUSY: begin
                    state_next_s = state_r;
                    cnt_next_s   = cnt_r;
                end
                TR_NONSEQ: begin
                    // An undefined burst whose owner has withdrawn is handed over here.
                    if ((state_r == ST_UNDEF) && !own_req_s) begin
                        state_next_s = ST_OPEN;
                        cnt_next_s   = 4'd0;
                    end else if (fixed_s) begin
                        state_next_s = ST_FIXED;
                        cnt_next_s   = burst_remaining(bus.HBURST);
                    end else if (bus.HBURST == BU_INCR) begin
                        state_next_s = ST_UNDEF;
                        cnt_next_s   = 4'd0;
                    end else begin
                        state_next_s = ST_OPEN;
                        cnt_next_s   = 4'd0;
                    end
                end
                TR_SEQ: begin
                    cnt_next_s = (cnt_r != 4'd0) ? (cnt_r - 4'd1) : 4'd0;
                    case (state_r)
                        ST_FIXED: state_next_s = (cnt_r <= 4'd1) ? ST_OPEN : ST_FIXED;
                        ST_UNDEF: state_next_s = own_req_s ? ST_UNDEF : ST_OPEN;
                        default:  state_next_s = state_r;
                    endcase
                end
                default: begin
                    state_next_s = state_r;
                    cnt_next_s   = cnt_r;
                end
            endcase
        end else begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
        end
    end

    // Handover eligibility and winner selection for this edge.
    always_comb begin
        rearb_s  = 1'b0;
        winner_s = DEFAULT_MASTER;
        if (bus.HREADY && !own_lock_s) begin
            rearb_s = (bus.HTRANS == TR_IDLE)
                    | (accept_s && (bus.HTRANS == TR_NONSEQ) && (bus.HBURST == BU_SINGLE))
                    | ((state_r == ST_FIXED) && (bus.HTRANS == TR_SEQ) && (cnt_r == 4'd1))
                    | ((state_r == ST_UNDEF) && accept_s && !own_req_s);
        end else begin
            rearb_s = 1'b0;
        end
        case (bus.HBUSREQ)
            2'b01:   winner_s = 1'b0;
            2'b10:   winner_s = 1'b1;
            2'b11:   winner_s = PRIORITY_MODE ? 1'b0 : ~last_r;
            default: winner_s = DEFAULT_MASTER;
        endcase
    end

    // Burst tracker state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r <= ST_OPEN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered grant, master selects, lock flag and round-robin history.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hgrant_r    <= DEFAULT_MASTER ? 2'b10 : 2'b01;
            hmaster_r   <= DEFAULT_MASTER;
            hmaster_d_r <= DEFAULT_MASTER;
            hmastlock_r <= 1'b0;
            last_r      <= DEFAULT_MASTER;
        end else if (bus.HREADY) begin
            hmaster_d_r <= hmaster_r;
            if (rearb_s) begin
                hgrant_r    <= {winner_s, ~winner_s};
                hmaster_r   <= winner_s;
                hmastlock_r <= bus.HLOCK[winner_s];
                last_r      <= winner_s;
            end else begin
                hgrant_r    <= hgrant_r;
                hmaster_r   <= hmaster_r;
                hmastlock_r <= hmastlock_r;
                last_r      <= last_r;
            end
        end else begin
            hgrant_r    <= hgrant_r;
            hmaster_r   <= hmaster_r;
            hmaster_d_r <= hmaster_d_r;
            hmastlock_r <= hmastlock_r;
            last_r      <= last_r;
        end
    end

endmodule
